// File: rtl/ucdp_pulse_snd_pkg.sv
// Shared types and constants for the pulse sender: FSM state encoding
// and the ack synchronizer depth (which is also the completion latency).
package ucdp_pulse_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam int unsigned CompLat = 2;

endpackage

// File: rtl/ucdp_sync.sv
// Level synchronizer, CompLat flops deep, with optional edge output.
// Reset is held off during scan shift so the chain shifts cleanly.
module ucdp_sync
  import ucdp_pulse_snd_pkg::*;
#(
  parameter logic [1:0] edge_type_p   = 2'h0,
  parameter logic       rstval_p      = 1'b0,
  parameter logic       norstvalchk_p = 1'b0
) (
  input  logic main_clk_i,
  input  logic main_rst_an_i,
  input  logic dft_mode_scan_shift_i,
  input  logic d_i,
  output logic q_o
);

  logic               w_rst_an;
  logic               w_lvl;
  logic [CompLat-1:0] r_sync;
  logic               r_lvl_d;

  assign w_rst_an = main_rst_an_i | dft_mode_scan_shift_i;
  assign w_lvl    = r_sync[CompLat-1];

  always_ff @(posedge main_clk_i or negedge w_rst_an) begin
    if (!w_rst_an) begin
      r_sync  <= {CompLat{rstval_p}};
      r_lvl_d <= rstval_p;
    end else begin
      r_sync  <= {r_sync[CompLat-2:0], d_i};
      r_lvl_d <= w_lvl;
    end
  end

  // 0: level, 1: rising edge, 2: falling edge, 3: any edge
  always_comb begin
    case (edge_type_p)
      2'h1:    q_o = w_lvl & ~r_lvl_d;
      2'h2:    q_o = ~w_lvl & r_lvl_d;
      2'h3:    q_o = w_lvl ^ r_lvl_d;
      default: q_o = w_lvl;
    endcase
  end

  // The far side must leave reset at the same level, or a phantom edge appears.
  generate
    if (!norstvalchk_p) begin : g_rstval_chk
      a_rstval : assert property (@(posedge main_clk_i) $rose(main_rst_an_i) |-> (d_i == rstval_p));
    end
  endgenerate

endmodule

// File: rtl/ucdp_pulse_snd.sv
// Source side of a 2-phase toggle pulse crossing with optional one-deep
// pending slot, sticky drop/timeout flags; done_o follows an ack edge by 2 cycles.
module ucdp_pulse_snd
  import ucdp_pulse_snd_pkg::*;
#(
  parameter logic        rstval_p    = 1'b0,
  parameter logic        pend_en_p   = 1'b1,
  parameter int unsigned tmo_width_p = 8
) (
  input  logic main_clk_i,
  input  logic main_rst_an_i,
  input  logic dft_mode_scan_shift_i,
  input  logic pulse_i,
  output logic req_o,
  input  logic ack_i,
  input  logic clr_i,
  output logic busy_o,
  output logic done_o,
  output logic ovfl_o,
  output logic tmo_o
);

  localparam logic [tmo_width_p-1:0] CntMax = '1;
  localparam logic [tmo_width_p-1:0] CntOne = {{(tmo_width_p-1){1'b0}}, 1'b1};

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_req;
  logic                   r_ovfl;
  logic                   r_tmo;
  logic [tmo_width_p-1:0] r_cnt;
  logic                   w_ack_s;
  logic                   w_busy;
  logic                   w_comp;
  logic                   w_tgl;
  logic                   w_drop;
  logic                   w_wait;

  ucdp_sync #(
    .edge_type_p  (2'h0),
    .rstval_p     (rstval_p),
    .norstvalchk_p(1'b0)
  ) u_ack_sync (
    .main_clk_i           (main_clk_i),
    .main_rst_an_i        (main_rst_an_i),
    .dft_mode_scan_shift_i(dft_mode_scan_shift_i),
    .d_i                  (ack_i),
    .q_o                  (w_ack_s)
  );

  assign w_busy = (r_state != ST_IDLE);
  assign w_comp = w_busy && (w_ack_s == r_req);
  assign w_wait = w_busy && !w_comp;

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (pulse_i) w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (!w_comp) begin
          if (pulse_i && pend_en_p) w_state_nxt = ST_PEND;
        end else if (!pulse_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: if (w_comp) w_state_nxt = pulse_i ? ST_PEND : ST_BUSY;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tgl  = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      ST_IDLE: w_tgl = pulse_i;
      ST_BUSY: begin
        if (w_comp) w_tgl  = pulse_i;
        else        w_drop = pulse_i & ~pend_en_p;
      end
      ST_PEND: begin
        if (w_comp) w_tgl  = 1'b1;
        else        w_drop = pulse_i;
      end
      default: ;
    endcase
  end

  // Timeout is observational only: it never feeds back into the FSM.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_req  <= rstval_p;
      r_cnt  <= '0;
      r_ovfl <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      if (w_tgl) r_req <= ~r_req;
      if (w_tgl) begin
        r_cnt <= '0;
      end else if (w_wait && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CntOne;
      end
      r_ovfl <= w_drop | (r_ovfl & ~clr_i);
      r_tmo  <= (w_wait && (r_cnt == CntMax)) | (r_tmo & ~clr_i);
    end
  end

  assign req_o  = r_req;
  assign busy_o = w_busy;
  assign done_o = w_comp;
  assign ovfl_o = r_ovfl;
  assign tmo_o  = r_tmo;

endmodule

// File: tb/tb_ucdp_pulse_snd.sv
// Bench for ucdp_pulse_snd: three parameterisations share one logical stimulus,
// a transfer-count model predicts every output each cycle, plus literal spot checks.
module tb_ucdp_pulse_snd;

  logic clk = 1'b0;
  logic rst_n;
  logic scan;
  logic pulse;
  logic clr;
  logic ack;
  logic ack_b;
  logic run = 1'b0;

  logic [2:0] req_w, busy_w, done_w, ovfl_w, tmo_w;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ack_b = ~ack;

  // A: rstval 0, pending, 4-bit timer. B: rstval 1, pending, 8-bit. C: rstval 0, no pending, 4-bit.
  ucdp_pulse_snd #(.rstval_p(1'b0), .pend_en_p(1'b1), .tmo_width_p(4)) u_dut_a (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .dft_mode_scan_shift_i(scan),
    .pulse_i(pulse), .req_o(req_w[0]), .ack_i(ack), .clr_i(clr),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .ovfl_o(ovfl_w[0]), .tmo_o(tmo_w[0]));

  ucdp_pulse_snd #(.rstval_p(1'b1), .pend_en_p(1'b1), .tmo_width_p(8)) u_dut_b (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .dft_mode_scan_shift_i(scan),
    .pulse_i(pulse), .req_o(req_w[1]), .ack_i(ack_b), .clr_i(clr),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .ovfl_o(ovfl_w[1]), .tmo_o(tmo_w[1]));

  ucdp_pulse_snd #(.rstval_p(1'b0), .pend_en_p(1'b0), .tmo_width_p(4)) u_dut_c (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .dft_mode_scan_shift_i(scan),
    .pulse_i(pulse), .req_o(req_w[2]), .ack_i(ack), .clr_i(clr),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .ovfl_o(ovfl_w[2]), .tmo_o(tmo_w[2]));

  function automatic int tmax(int i);
    return (i == 1) ? 255 : 15;
  endfunction

  function automatic int cap(int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic bit rstv(int i);
    return (i == 1);
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model in logical (rstval-normalised) terms: m_n = transfers accepted but not yet acked.
  bit m_req[3];
  int m_n[3];
  int m_cnt[3];
  bit m_ovfl[3];
  bit m_tmo[3];
  bit m_s1, m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_req[i] = 1'b0; m_n[i] = 0; m_cnt[i] = 0; m_ovfl[i] = 1'b0; m_tmo[i] = 1'b0;
      end
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit busy, comp, tg, drop, waiting;
        int n;
        busy    = (m_n[i] > 0);
        comp    = busy && (m_s2 == m_req[i]);
        waiting = busy && !comp;
        n       = m_n[i] - (comp ? 1 : 0);
        tg      = comp && (n > 0);
        drop    = 1'b0;
        if (pulse) begin
          if (n == 0) begin
            tg = 1'b1;
            n  = 1;
          end else if (n < cap(i)) begin
            n++;
          end else begin
            drop = 1'b1;
          end
        end
        m_tmo[i] = (waiting && m_cnt[i] == tmax(i)) || (m_tmo[i] && !clr);
        if (tg) m_cnt[i] = 0;
        else if (waiting && m_cnt[i] < tmax(i)) m_cnt[i]++;
        if (tg) m_req[i] = ~m_req[i];
        m_n[i]    = n;
        m_ovfl[i] = drop || (m_ovfl[i] && !clr);
      end
      m_s2 = m_s1;
      m_s1 = ack;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d_req", i), req_w[i], m_req[i] ^ rstv(i));
        chk($sformatf("m%0d_busy", i), busy_w[i], m_n[i] > 0);
        chk($sformatf("m%0d_done", i), done_w[i], (m_n[i] > 0) && (m_s2 == m_req[i]));
        chk($sformatf("m%0d_ovfl", i), ovfl_w[i], m_ovfl[i]);
        chk($sformatf("m%0d_tmo", i), tmo_w[i], m_tmo[i]);
      end
    end
  end

  initial begin
    pulse = 1'b0; clr = 1'b0; ack = 1'b0; scan = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    run = 1'b1;
    tk(3);
    chk("rst_req_a", req_w[0], 1'b0);
    chk("rst_req_b", req_w[1], 1'b1);
    chk("rst_busy_a", busy_w[0], 1'b0);
    chk("rst_done_b", done_w[1], 1'b0);
    rst_n = 1'b1;
    tk(3);

    // basic transfer
    pulse = 1'b1; tk(1); pulse = 1'b0;
    chk("basic_req_a", req_w[0], 1'b1);
    chk("basic_req_b", req_w[1], 1'b0);
    chk("basic_busy_a", busy_w[0], 1'b1);
    tk(4); ack = 1'b1;
    tk(1); chk("basic_done_early", done_w[0], 1'b0);
    tk(1); chk("basic_done", done_w[0], 1'b1);
    tk(1); chk("basic_done_once", done_w[0], 1'b0);
    chk("basic_idle", busy_w[0], 1'b0);
    tk(2);

    // pending slot (A), drop without pending slot (C)
    pulse = 1'b1; tk(1); pulse = 1'b0;
    chk("pend_req_a", req_w[0], 1'b0);
    tk(2); pulse = 1'b1;
    tk(1); pulse = 1'b0;
    chk("nopend_ovfl_c", ovfl_w[2], 1'b1);
    chk("pend_ovfl_a", ovfl_w[0], 1'b0);
    tk(1); ack = 1'b0;
    tk(2); chk("pend_done_a", done_w[0], 1'b1);
    tk(1); chk("pend_req2_a", req_w[0], 1'b1);
    chk("pend_busy_a", busy_w[0], 1'b1);
    chk("pend_noovfl_a", ovfl_w[0], 1'b0);
    tk(1); ack = 1'b1;
    tk(2); chk("pend_done2_a", done_w[0], 1'b1);
    tk(1); chk("pend_idle_a", busy_w[0], 1'b0);
    clr = 1'b1; tk(1); clr = 1'b0;
    chk("clr_ovfl_c", ovfl_w[2], 1'b0);
    tk(1);

    // overflow, clear, clear-vs-drop, timeout, late ack
    pulse = 1'b1; tk(1); pulse = 1'b0;
    tk(1); pulse = 1'b1;
    tk(1); chk("ovfl_pre_a", ovfl_w[0], 1'b0);
    tk(1); pulse = 1'b0;
    chk("ovfl_set_a", ovfl_w[0], 1'b1);
    tk(6); clr = 1'b1;
    tk(1); clr = 1'b0;
    chk("ovfl_clr_a", ovfl_w[0], 1'b0);
    tk(1); pulse = 1'b1; clr = 1'b1;
    tk(1); pulse = 1'b0; clr = 1'b0;
    chk("clr_vs_drop_a", ovfl_w[0], 1'b1);
    tk(1); clr = 1'b1;
    tk(1); clr = 1'b0;
    chk("ovfl_clr2_a", ovfl_w[0], 1'b0);
    tk(1); chk("tmo_pre_a", tmo_w[0], 1'b0);
    tk(1); chk("tmo_set_a", tmo_w[0], 1'b1);
    chk("tmo_b_quiet", tmo_w[1], 1'b0);
    tk(3); ack = 1'b0;
    tk(2); chk("late_done_a", done_w[0], 1'b1);
    chk("late_tmo_sticky_a", tmo_w[0], 1'b1);
    tk(4); ack = 1'b1;
    tk(2); chk("late_done2_a", done_w[0], 1'b1);
    tk(1); chk("late_idle_a", busy_w[0], 1'b0);
    clr = 1'b1; tk(1); clr = 1'b0;
    chk("tmo_clr_a", tmo_w[0], 1'b0);
    tk(1);

    // pulse coinciding with completion in BUSY
    pulse = 1'b1; tk(1); pulse = 1'b0;
    chk("sim_req_a", req_w[0], 1'b0);
    tk(2); ack = 1'b0;
    tk(2); chk("sim_done_a", done_w[0], 1'b1);
    pulse = 1'b1; tk(1); pulse = 1'b0;
    chk("sim_req2_a", req_w[0], 1'b1);
    chk("sim_busy_a", busy_w[0], 1'b1);
    chk("sim_noovfl_a", ovfl_w[0], 1'b0);
    tk(2); ack = 1'b1;
    tk(2); chk("sim_done2_a", done_w[0], 1'b1);
    tk(1); chk("sim_idle_a", busy_w[0], 1'b0);
    tk(1);

    // reset while in PEND, rstval 1 instance
    pulse = 1'b1; tk(1);
    tk(1); pulse = 1'b0; ack = 1'b0;
    tk(2); chk("rp_done_b", done_w[1], 1'b1);
    tk(1); pulse = 1'b1;
    tk(1); pulse = 1'b0;
    tk(1); chk("rp_req_pre_b", req_w[1], 1'b0);
    chk("rp_busy_pre_b", busy_w[1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rp_req_b", req_w[1], 1'b1);
    chk("rp_busy_b", busy_w[1], 1'b0);
    chk("rp_done_rst_b", done_w[1], 1'b0);
    chk("rp_ovfl_b", ovfl_w[1], 1'b0);
    chk("rp_tmo_b", tmo_w[1], 1'b0);
    tk(2); rst_n = 1'b1;
    tk(1); chk("rp_nodone1_b", done_w[1], 1'b0);
    tk(1); chk("rp_nodone2_b", done_w[1], 1'b0);
    chk("rp_idle_b", busy_w[1], 1'b0);
    tk(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ucdp_pulse_snd.md
UCDP_PULSE_SND -- requirements
Module: ucdp_pulse_snd

Interface
REQ-001 SHALL have parameter rstval_p, default 1'b0: reset level of req_o, which is also the expected reset level of ack_i.
REQ-002 SHALL have parameter pend_en_p, default 1'b1: 1 enables a one-deep pending slot, 0 disables it.
REQ-003 SHALL have parameter tmo_width_p, default 8: width of the handshake-timeout counter, legal range 2..16.
REQ-004 SHALL have port main_clk_i, input, 1 bit: clock.
REQ-005 SHALL have port main_rst_an_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port dft_mode_scan_shift_i, input, 1 bit: scan shift phase, forwarded to the synchronizer.
REQ-007 SHALL have port pulse_i, input, 1 bit: single-cycle transfer request, source domain.
REQ-008 SHALL have port req_o, output, 1 bit: 2-phase toggle request toward the destination domain.
REQ-009 SHALL have port ack_i, input, 1 bit: 2-phase toggle acknowledge from the destination domain, asynchronous.
REQ-010 SHALL have port clr_i, input, 1 bit: clears the sticky flags.
REQ-011 SHALL have port busy_o, output, 1 bit: a transfer is outstanding.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle handshake-complete strobe.
REQ-013 SHALL have port ovfl_o, output, 1 bit: sticky flag, a pulse was dropped.
REQ-014 SHALL have port tmo_o, output, 1 bit: sticky flag, handshake timeout.

Function
REQ-015 SHALL synchronize ack_i into main_clk_i with a 2-stage synchronizer (L=2); the synchronized value is ack_s.
REQ-016 SHALL implement the FSM states IDLE, BUSY and PEND; PEND is unreachable when pend_en_p=0.
REQ-017 SHALL, in IDLE with pulse_i=1, toggle the registered req_o at the next edge and go to BUSY.
REQ-018 SHALL define completion as (state != IDLE) and (ack_s == req_o); done_o equals completion, combinationally, for exactly one cycle.
REQ-019 SHALL, on completion in BUSY with pulse_i=0, go to IDLE.
REQ-020 SHALL, on completion in BUSY with pulse_i=1, accept the pulse: toggle req_o and stay in BUSY, with no drop.
REQ-021 SHALL, in BUSY without completion and pulse_i=1, go to PEND if pend_en_p=1; otherwise it drops the pulse and sets ovfl_o.
REQ-022 SHALL, on completion in PEND, toggle req_o and go to BUSY; a pulse_i in that same cycle moves the FSM to PEND instead.
REQ-023 SHALL, in PEND without completion and pulse_i=1, drop the pulse and set ovfl_o.
REQ-024 SHALL drive busy_o = (state != IDLE).
REQ-025 SHALL clear the timeout counter on every req_o toggle, count up each cycle while busy_o=1 and completion=0, and saturate at all-ones.
REQ-026 SHALL set tmo_o when the timeout counter reaches all-ones; a timeout never aborts the handshake or alters the FSM.
REQ-027 SHALL clear ovfl_o and tmo_o at the clock edge when clr_i=1; if a set event and clr_i occur in the same cycle, set wins.
REQ-028 SHALL give a pulse-to-req_o latency of 1 cycle, and an ack_i-edge-to-done_o latency of L=2 cycles.

Reset
REQ-029 SHALL apply these reset values: req_o=rstval_p, state=IDLE, busy_o=0, done_o=0, ovfl_o=0, tmo_o=0, counter=0.
REQ-030 SHALL reset the synchronizer to rstval_p, so that ack_s == req_o out of reset and no spurious done_o occurs.
REQ-031 SHALL abort an in-flight transfer when reset is asserted mid-operation; the destination side is required to be reset concurrently.

Structure
REQ-032 SHALL define the FSM state enum type and the completion-latency constant (2) in package ucdp_pulse_snd_pkg.
REQ-033 SHALL instantiate ucdp_sync once as sub-module u_ack_sync, with edge_type_p=2'h0, rstval_p=rstval_p and norstvalchk_p=1'b0.
REQ-034 SHALL contain no combinational path from ack_i to any output; done_o is derived only from ack_s.

Verification
REQ-035 Basic transfer: rstval_p=0; pulse at cycle 10 -> req_o=1 at cycle 11; ack_i=1 at cycle 15 -> done_o=1 in cycle 17 only, busy_o=0 from cycle 18.
REQ-036 Pending: pend_en_p=1; pulses at cycles 10 and 13; ack at cycle 15 -> done_o at 17, req_o=0 at 18, busy_o stays 1, ovfl_o=0.
REQ-037 Overflow: pend_en_p=1; pulses at cycles 10, 12 and 13 with no ack -> ovfl_o=1 from cycle 14; clr_i at cycle 20 -> ovfl_o=0 at cycle 21.
REQ-038 Timeout: tmo_width_p=4; pulse with no ack -> tmo_o=1 16 cycles after req_o toggles; a late ack still completes with done_o=1.
REQ-039 Simultaneous events: pulse_i in the same cycle as completion in BUSY -> req_o toggles, no drop; clr_i together with a drop -> ovfl_o=1.
REQ-040 Reset: rstval_p=1; assert reset while in PEND -> req_o=1, state IDLE, all flags 0; release reset with ack_i=1 -> no done_o.
